// File: rtl/clic_arb_pkg.sv
// clic_arb_pkg: shared types and constants for the CLIC interrupt arbiter.
//   state_e  - handshake FSM states (IDLE, OFFER, ACK)
//   trig_e   - per-source trigger mode (level-high / rising edge)
//   winner_t - one arbitration candidate: valid, id, clicintctl, shv
//   merge    - two-input reduction step: higher ctl wins, left (lower id) on tie
// winner_t fields are sized for the largest supported configuration
// (1024 sources, up to 16 ctl bits); users slice out what they need.
package clic_arb_pkg;

  localparam int CtlWidthDef = 8;
  localparam int MaxIdWidth  = 10;
  localparam int MaxCtlWidth = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACK   = 2'd2
  } state_e;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_e;

  typedef struct packed {
    logic                   vld;
    logic [MaxIdWidth-1:0]  id;
    logic [MaxCtlWidth-1:0] ctl;
    logic                   shv;
  } winner_t;

  // 'a' must always be the lower-index operand so that ties keep it.
  function automatic winner_t merge(input winner_t a, input winner_t b);
    if (b.vld && (!a.vld || (b.ctl > a.ctl))) begin
      return b;
    end
    return a;
  endfunction

endpackage

// File: rtl/clic_arb_tree.sv
// clic_arb_tree: max-ctl / lowest-index reduction over eligible sources.
//   clk, rst  - clock and synchronous active-high reset (pipeline register only)
//   eligible  - per-source eligibility
//   ctl       - per-source clicintctl, flattened NumSrc*CtlWidth
//   shv       - per-source shv bit
//   win       - winning candidate (win.vld=0 when nothing is eligible)
// Build option CLIC_ARB_PIPE_TREE_EN: registers the tree at its middle level,
// adding one cycle of latency. Without it the tree is purely combinational.
// Nodes are kept heap-ordered (node k has children 2k and 2k+1), so the
// left child always covers lower source indices.
module clic_arb_tree
  import clic_arb_pkg::*;
#(
  parameter int NumSrc   = 64,
  parameter int CtlWidth = CtlWidthDef
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumSrc-1:0]          eligible,
  input  logic [NumSrc*CtlWidth-1:0] ctl,
  input  logic [NumSrc-1:0]          shv,
  output winner_t                    win
);

  localparam int Depth  = $clog2(NumSrc);
  localparam int Leaves = 1 << Depth;
  localparam int MidLvl = Depth / 2;
  localparam int MidW   = 1 << MidLvl;

  winner_t lo_n  [1:2*Leaves-1];
  winner_t mid_d [MidW];
  winner_t mid_v [MidW];
  winner_t hi_n  [1:2*MidW-1];

  // Lower half: leaves up to the middle level.
  always_comb begin
    for (int k = 1; k < 2*Leaves; k++) begin
      lo_n[k] = '0;
    end
    for (int i = 0; i < NumSrc; i++) begin
      lo_n[Leaves+i].vld = eligible[i];
      lo_n[Leaves+i].id  = MaxIdWidth'(i);
      lo_n[Leaves+i].ctl = MaxCtlWidth'(ctl[i*CtlWidth +: CtlWidth]);
      lo_n[Leaves+i].shv = shv[i];
    end
    for (int k = Leaves - 1; k >= MidW; k--) begin
      lo_n[k] = merge(lo_n[2*k], lo_n[2*k+1]);
    end
    for (int j = 0; j < MidW; j++) begin
      mid_d[j] = lo_n[MidW+j];
    end
  end

`ifdef CLIC_ARB_PIPE_TREE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < MidW; j++) begin
        mid_v[j] <= '0;
      end
    end else begin
      for (int j = 0; j < MidW; j++) begin
        mid_v[j] <= mid_d[j];
      end
    end
  end
`else
  always_comb begin
    for (int j = 0; j < MidW; j++) begin
      mid_v[j] = mid_d[j];
    end
  end

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

  // Upper half: middle level up to the root.
  always_comb begin
    for (int k = 1; k < 2*MidW; k++) begin
      hi_n[k] = '0;
    end
    for (int j = 0; j < MidW; j++) begin
      hi_n[MidW+j] = mid_v[j];
    end
    for (int k = MidW - 1; k >= 1; k--) begin
      hi_n[k] = merge(hi_n[2*k], hi_n[2*k+1]);
    end
  end

  assign win = hi_n[1];

endmodule

// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: picks the highest-ranked pending, enabled CLIC interrupt
// and offers it to the core over a valid/ready handshake.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   src_i          - raw interrupt lines
//   ie_i           - per-source enable
//   edge_i         - per-source trigger: 1 = rising edge, 0 = level-high
//   ctl_i          - per-source clicintctl (level in MSBs), NumSrc*CtlWidth
//   shv_i          - per-source selective-hardware-vectoring bit
//   thresh_i       - threshold; a source needs ctl > thresh (unsigned)
//   irq_valid_o    - interrupt offered
//   irq_ready_i    - core accepts the offer
//   irq_id_o/irq_ctl_o/irq_shv_o - offered source, zero while not valid
//   dbg_state      - current handshake FSM state
// Handshake: irq_valid_o rises with a registered offer and the offered
// id/ctl/shv stay frozen until either the core raises irq_ready_i (transfer
// happens in that cycle, valid drops next cycle) or the offered source loses
// eligibility with ready low (offer withdrawn, valid drops next cycle).
// irq_ready_i is only looked at while offering and never reaches an output
// combinationally.
// Build option CLIC_ARB_PIPE_TREE_EN: pipelined comparator tree (latency 3,
// two-cycle ACK bubble). Default: single-stage tree (latency 2, one bubble).
module clic_irq_arbiter
  import clic_arb_pkg::*;
#(
  parameter int NumSrc   = 64,
  parameter int CtlWidth = CtlWidthDef,
  parameter int IdWidth  = $clog2(NumSrc)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumSrc-1:0]          src_i,
  input  logic [NumSrc-1:0]          ie_i,
  input  logic [NumSrc-1:0]          edge_i,
  input  logic [NumSrc*CtlWidth-1:0] ctl_i,
  input  logic [NumSrc-1:0]          shv_i,
  input  logic [CtlWidth-1:0]        thresh_i,
  output logic                       irq_valid_o,
  input  logic                       irq_ready_i,
  output logic [IdWidth-1:0]         irq_id_o,
  output logic [CtlWidth-1:0]        irq_ctl_o,
  output logic                       irq_shv_o,
  output state_e                     dbg_state
);

  // The bubble must outlast the tree latency so a cleared latch is visible
  // at the root before the next arbitration.
`ifdef CLIC_ARB_PIPE_TREE_EN
  localparam logic AckLast = 1'b1;
`else
  localparam logic AckLast = 1'b0;
`endif

  state_e               state_q, state_d;
  logic                 ack_cnt_q, ack_cnt_d;
  logic                 load;
  logic [NumSrc-1:0]    src_q, pending_q, pending_d, clr, eligible;
  logic [IdWidth-1:0]   winner_id_q;
  logic [CtlWidth-1:0]  winner_ctl_q;
  logic                 winner_shv_q;
  winner_t              tree_win;

  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      eligible[i] = pending_q[i] & ie_i[i] &
                    (ctl_i[i*CtlWidth +: CtlWidth] > thresh_i);
    end
  end

  // Clear pulse for the accepted source; level sources ignore it.
  always_comb begin
    clr = '0;
    if ((state_q == OFFER) && irq_ready_i && !rst_i) begin
      clr[winner_id_q] = 1'b1;
    end
  end

  // Edge latches: a new edge in the accept cycle beats the clear.
  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      if (trig_e'(edge_i[i]) == TRIG_EDGE) begin
        pending_d[i] = (pending_q[i] & ~clr[i]) | (src_i[i] & ~src_q[i]);
      end else begin
        pending_d[i] = src_i[i];
      end
    end
  end

  clic_arb_tree #(
    .NumSrc   (NumSrc),
    .CtlWidth (CtlWidth)
  ) u_tree (
    .clk      (clk_i),
    .rst      (rst_i),
    .eligible (eligible),
    .ctl      (ctl_i),
    .shv      (shv_i),
    .win      (tree_win)
  );

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tree_win.vld) begin
          state_d = OFFER;
          load    = 1'b1;
        end
      end
      OFFER: begin
        // Ready has priority over a simultaneous loss of eligibility.
        if (irq_ready_i) begin
          state_d   = ACK;
          ack_cnt_d = AckLast;
        end else if (!eligible[winner_id_q]) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (ack_cnt_q == 1'b0) begin
          state_d = IDLE;
        end else begin
          ack_cnt_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ack_cnt_q    <= 1'b0;
      src_q        <= '0;
      pending_q    <= '0;
      winner_id_q  <= '0;
      winner_ctl_q <= '0;
      winner_shv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      src_q     <= src_i;
      pending_q <= pending_d;
      if (load) begin
        winner_id_q  <= tree_win.id[IdWidth-1:0];
        winner_ctl_q <= tree_win.ctl[CtlWidth-1:0];
        winner_shv_q <= tree_win.shv;
      end
    end
  end

  assign irq_valid_o = (state_q == OFFER);
  assign irq_id_o    = irq_valid_o ? winner_id_q  : '0;
  assign irq_ctl_o   = irq_valid_o ? winner_ctl_q : '0;
  assign irq_shv_o   = irq_valid_o & winner_shv_q;
  assign dbg_state   = state_q;

  logic unused_win;
  assign unused_win = ^{tree_win.id, tree_win.ctl};

endmodule
